pooling_sampler: RTL and testbench

POOLING_SAMPLER -- requirements
Module: pooling_sampler

---
 rtl/pooling_sampler.sv | 146 ++++++++++++++
 tb/tb_pooling_sampler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_sampler.sv
// pooling_sampler: streaming max/average pooling over POOL_K x POOL_K windows
// with stride POOL_K. Pixels arrive in raster order. Each row is reduced
// horizontally in a running register, and that partial is merged vertically
// through a one-row line buffer. Results are registered, with 1-cycle latency.
module pooling_sampler #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int POOL_K = 2
) (
    input  logic              Clock,
    input  logic              Input_Reset,
    input  logic [DATA_W-1:0] Input_Pixel,
    input  logic              Input_Valid,
    input  logic              Input_Finish,
    input  logic              Input_Mode,
    output logic [DATA_W-1:0] Output_Pixel,
    output logic              Output_Valid,
    output logic              Output_Finish,
    output logic [15:0]       Watch
);

    localparam int LOG_K = (POOL_K == 4) ? 2 : 1;
    localparam int ACC_W = DATA_W + 2 * LOG_K;
    localparam int NCOL  = IMG_W / POOL_K;
    localparam int IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;

    localparam logic [7:0]       COL_LAST = 8'(IMG_W - 1);
    localparam logic [7:0]       ROW_LAST = 8'(IMG_H - 1);
    localparam logic [LOG_K-1:0] POS_LAST = '1;

    generate
        if (POOL_K != 2 && POOL_K != 4) begin : g_bad_pool_k
            $error("pooling_sampler: POOL_K must be 2 or 4");
        end
        if ((IMG_W % POOL_K) != 0 || IMG_W > 255 || IMG_W < POOL_K) begin : g_bad_img_w
            $error("pooling_sampler: IMG_W must be a multiple of POOL_K and at most 255");
        end
        if ((IMG_H % POOL_K) != 0 || IMG_H > 255 || IMG_H < POOL_K) begin : g_bad_img_h
            $error("pooling_sampler: IMG_H must be a multiple of POOL_K and at most 255");
        end
    endgenerate

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } mode_e;

    logic [7:0]               col_q;
    logic [7:0]               row_q;
    mode_e                    mode_q;
    mode_e                    mode_cur;
    logic signed [ACC_W-1:0]  run_q;
    logic signed [ACC_W-1:0]  run_next;
    logic signed [ACC_W-1:0]  lb_rd;
    logic signed [ACC_W-1:0]  win_next;
    logic signed [ACC_W-1:0]  px_ext;
    logic [DATA_W-1:0]        out_next;
    logic signed [ACC_W-1:0]  lb_mem [NCOL];
    logic [IDX_W-1:0]         idx;
    logic                     frame_start;
    logic                     win_col_end;
    logic                     win_row_end;
    logic                     last_col;
    logic                     last_row;

    // Two pixels or partials folded according to the pooling mode.
    function automatic logic signed [ACC_W-1:0] merge(
        input mode_e                   m,
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        if (m == MODE_AVG) begin
            return a + b;
        end
        return (a > b) ? a : b;
    endfunction

    assign px_ext      = {{(2 * LOG_K){Input_Pixel[DATA_W-1]}}, Input_Pixel};
    assign idx         = IDX_W'(col_q >> LOG_K);
    assign frame_start = (row_q == '0) && (col_q == '0);
    assign win_col_end = (col_q[LOG_K-1:0] == POS_LAST);
    assign win_row_end = (row_q[LOG_K-1:0] == POS_LAST);
    assign last_col    = (col_q == COL_LAST);
    assign last_row    = (row_q == ROW_LAST);
    assign Watch       = {row_q, col_q};

    // Datapath: horizontal fold, vertical merge with line buffer, final scaling.
    // The first row of a window takes the fresh partial, so stale buffer
    // contents (after reset or an abort) are never merged in.
    always_comb begin
        mode_cur = frame_start ? mode_e'(Input_Mode) : mode_q;
        run_next = (col_q[LOG_K-1:0] == '0) ? px_ext : merge(mode_cur, run_q, px_ext);
        lb_rd    = lb_mem[idx];
        win_next = (row_q[LOG_K-1:0] == '0) ? run_next : merge(mode_cur, lb_rd, run_next);
        out_next = (mode_cur == MODE_AVG) ? DATA_W'(win_next >>> (2 * LOG_K))
                                          : DATA_W'(win_next);
    end

    // Line buffer write of each completed horizontal partial; contents need no reset.
    always_ff @(posedge Clock) begin
        if (Input_Valid && win_col_end) begin
            lb_mem[idx] <= win_next;
        end
    end

    // Counters, mode latch, running register, and registered outputs.
    always_ff @(posedge Clock or negedge Input_Reset) begin
        if (!Input_Reset) begin
            col_q         <= '0;
            row_q         <= '0;
            mode_q        <= MODE_MAX;
            run_q         <= '0;
            Output_Pixel  <= '0;
            Output_Valid  <= 1'b0;
            Output_Finish <= 1'b0;
        end else begin
            Output_Valid  <= 1'b0;
            Output_Finish <= Input_Finish || (Input_Valid && last_col && last_row);
            if (Input_Valid) begin
                if (frame_start) begin
                    mode_q <= mode_e'(Input_Mode);
                end
                run_q <= run_next;
                if (win_col_end && win_row_end) begin
                    Output_Valid <= 1'b1;
                    Output_Pixel <= out_next;
                end
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + 8'd1;
                end else begin
                    col_q <= col_q + 8'd1;
                end
            end
            // The pixel accepted alongside Input_Finish is processed first;
            // the frame then restarts from (0,0).
            if (Input_Finish) begin
                col_q <= '0;
                row_q <= '0;
                run_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pooling_sampler.sv
// tb_pooling_sampler: drives three pooling_sampler configurations (4x4 K=2,
// default 24x24 K=2, 8x8 K=4). Every cycle is checked against a frame-store
// reference model that computes each window directly from the stored pixels.
module tb_pooling_sampler;

    localparam int NI = 3;

    logic        Clock;
    logic        rst_n   [NI];
    logic        v_in    [NI];
    logic        f_in    [NI];
    logic        m_in    [NI];
    logic [15:0] p_in    [NI];
    logic [15:0] o_pix   [NI];
    logic [15:0] o_watch [NI];
    logic        o_val   [NI];
    logic        o_fin   [NI];

    int          n_checks;
    int          n_errors;

    // Reference model state
    int          m_r    [NI];
    int          m_c    [NI];
    bit          m_mode [NI];
    logic [15:0] m_last [NI];
    int          img    [256][256];
    logic [15:0] got_q  [$];
    int          fin_cnt;

    pooling_sampler #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .POOL_K(2)) u_small (
        .Clock(Clock), .Input_Reset(rst_n[0]), .Input_Pixel(p_in[0]), .Input_Valid(v_in[0]),
        .Input_Finish(f_in[0]), .Input_Mode(m_in[0]), .Output_Pixel(o_pix[0]),
        .Output_Valid(o_val[0]), .Output_Finish(o_fin[0]), .Watch(o_watch[0])
    );

    pooling_sampler u_default (
        .Clock(Clock), .Input_Reset(rst_n[1]), .Input_Pixel(p_in[1]), .Input_Valid(v_in[1]),
        .Input_Finish(f_in[1]), .Input_Mode(m_in[1]), .Output_Pixel(o_pix[1]),
        .Output_Valid(o_val[1]), .Output_Finish(o_fin[1]), .Watch(o_watch[1])
    );

    pooling_sampler #(.DATA_W(16), .IMG_W(8), .IMG_H(8), .POOL_K(4)) u_k4 (
        .Clock(Clock), .Input_Reset(rst_n[2]), .Input_Pixel(p_in[2]), .Input_Valid(v_in[2]),
        .Input_Finish(f_in[2]), .Input_Mode(m_in[2]), .Output_Pixel(o_pix[2]),
        .Output_Valid(o_val[2]), .Output_Finish(o_fin[2]), .Watch(o_watch[2])
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic int w_of(input int s);
        case (s)
            0:       return 4;
            1:       return 24;
            default: return 8;
        endcase
    endfunction

    function automatic int h_of(input int s);
        return w_of(s);
    endfunction

    function automatic int k_of(input int s);
        return (s == 2) ? 4 : 2;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare 1 ns later.
    task automatic step(input int s, input bit v, input logic [15:0] px, input bit f, input bit md);
        int  w  = w_of(s);
        int  h  = h_of(s);
        int  k  = k_of(s);
        bit  ev = 1'b0;
        bit  ef = 1'b0;
        int  sum;
        int  mx;
        int  q;
        int  n;
        v_in[s] = v;
        p_in[s] = px;
        f_in[s] = f;
        m_in[s] = md;
        @(posedge Clock);
        if (v) begin
            if (m_r[s] == 0 && m_c[s] == 0) m_mode[s] = md;
            img[m_r[s]][m_c[s]] = int'($signed(px));
            if ((m_r[s] % k) == k - 1 && (m_c[s] % k) == k - 1) begin
                sum = 0;
                mx  = img[m_r[s]][m_c[s]];
                for (int dr = 0; dr < k; dr++) begin
                    for (int dc = 0; dc < k; dc++) begin
                        int val = img[m_r[s] - k + 1 + dr][m_c[s] - k + 1 + dc];
                        sum += val;
                        if (val > mx) mx = val;
                    end
                end
                n = k * k;
                q = sum / n;
                if ((sum % n) != 0 && sum < 0) q = q - 1;
                m_last[s] = m_mode[s] ? 16'(q) : 16'(mx);
                ev = 1'b1;
            end
            if (m_c[s] == w - 1) begin
                m_c[s] = 0;
                if (m_r[s] == h - 1) begin
                    m_r[s] = 0;
                    ef     = 1'b1;
                end else begin
                    m_r[s] = m_r[s] + 1;
                end
            end else begin
                m_c[s] = m_c[s] + 1;
            end
        end
        if (f) begin
            m_r[s] = 0;
            m_c[s] = 0;
            ef     = 1'b1;
        end
        #1;
        check_value("valid",  32'(o_val[s]),   32'(ev));
        check_value("finish", 32'(o_fin[s]),   32'(ef));
        check_value("pixel",  32'(o_pix[s]),   32'(m_last[s]));
        check_value("watch",  32'(o_watch[s]), 32'({8'(m_r[s]), 8'(m_c[s])}));
        if (o_val[s]) got_q.push_back(o_pix[s]);
        if (o_fin[s]) fin_cnt++;
        @(negedge Clock);
        v_in[s] = 1'b0;
        f_in[s] = 1'b0;
    endtask

    task automatic apply_reset(input int s);
        rst_n[s] = 1'b0;
        #2;
        check_value("rst_pixel",  32'(o_pix[s]),   32'd0);
        check_value("rst_valid",  32'(o_val[s]),   32'd0);
        check_value("rst_finish", 32'(o_fin[s]),   32'd0);
        check_value("rst_watch",  32'(o_watch[s]), 32'd0);
        repeat (2) @(negedge Clock);
        rst_n[s]  = 1'b1;
        m_r[s]    = 0;
        m_c[s]    = 0;
        m_mode[s] = 1'b0;
        m_last[s] = '0;
    endtask

    function automatic logic [15:0] pixel_of(input int kind, input int i, input int w);
        case (kind)
            0: return 16'(i);
            1: begin
                if (i == 0)     return 16'hFFFF;
                if (i == 1)     return 16'hFFFE;
                if (i == w)     return 16'hFFFD;
                if (i == w + 1) return 16'hFFFC;
                return 16'h0000;
            end
            2: return 16'($urandom);
            default: return ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
        endcase
    endfunction

    // Pixels [0, npix) of a frame; optional idle gaps and mid-frame mode noise.
    task automatic run_pixels(input int s, input bit md, input int kind, input bit gaps,
                              input bit toggle, input bit fin_last, input int npix);
        int w = w_of(s);
        for (int i = 0; i < npix; i++) begin
            bit mb = (toggle && i != 0) ? 1'($urandom) : md;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) step(s, 1'b0, 16'($urandom), 1'b0, 1'($urandom));
            end
            step(s, 1'b1, pixel_of(kind, i, w), fin_last && (i == npix - 1), mb);
        end
    endtask

    task automatic run_frame(input int s, input bit md, input int kind, input bit gaps,
                             input bit toggle, input bit fin_last);
        run_pixels(s, md, kind, gaps, toggle, fin_last, w_of(s) * h_of(s));
    endtask

    task automatic expect4(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        logic [15:0] e [4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        check_value({tag, "_count"}, 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check_value($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(e[i]));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fin_cnt  = 0;
        for (int s = 0; s < NI; s++) begin
            rst_n[s] = 1'b0;
            v_in[s]  = 1'b0;
            f_in[s]  = 1'b0;
            m_in[s]  = 1'b0;
            p_in[s]  = '0;
        end
        @(negedge Clock);
        for (int s = 0; s < NI; s++) apply_reset(s);

        // Ramp frame, max then average
        got_q.delete(); fin_cnt = 0;
        run_frame(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        expect4("ramp_max", 16'd5, 16'd7, 16'd13, 16'd15);
        check_value("ramp_max_fin", 32'(fin_cnt), 32'd1);

        got_q.delete(); fin_cnt = 0;
        run_frame(0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        expect4("ramp_avg", 16'd2, 16'd4, 16'd10, 16'd12);

        // Negative top-left window
        got_q.delete();
        run_frame(0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        expect4("neg_max", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        got_q.delete();
        run_frame(0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        expect4("neg_avg", 16'hFFFD, 16'h0000, 16'h0000, 16'h0000);

        // Gaps and mode noise after the first pixel
        got_q.delete(); fin_cnt = 0;
        run_frame(0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        expect4("gap_max", 16'd5, 16'd7, 16'd13, 16'd15);
        check_value("gap_max_fin", 32'(fin_cnt), 32'd1);

        // Finish together with the last pixel pulses once
        fin_cnt = 0;
        run_frame(0, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        step(0, 1'b0, 16'h0, 1'b0, 1'b0);
        check_value("fin_last_once", 32'(fin_cnt), 32'd1);

        // Finish while idle at (0,0)
        fin_cnt = 0; got_q.delete();
        step(0, 1'b0, 16'h0, 1'b1, 1'b0);
        step(0, 1'b0, 16'h0, 1'b0, 1'b0);
        check_value("idle_fin_once", 32'(fin_cnt), 32'd1);
        check_value("idle_fin_nout", 32'(got_q.size()), 32'd0);

        // Abort via Input_Finish after 6 pixels, then a clean frame
        run_pixels(0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 6);
        step(0, 1'b0, 16'h0, 1'b1, 1'b0);
        got_q.delete();
        run_frame(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        expect4("abort_fin", 16'd5, 16'd7, 16'd13, 16'd15);

        // Abort with Finish on the 6th pixel
        run_pixels(0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 6);
        got_q.delete();
        run_frame(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        expect4("abort_fin_px", 16'd5, 16'd7, 16'd13, 16'd15);

        // Abort via reset after 6 pixels; no finish pulse
        fin_cnt = 0;
        run_pixels(0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 6);
        apply_reset(0);
        check_value("abort_rst_nofin", 32'(fin_cnt), 32'd0);
        got_q.delete();
        run_frame(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        expect4("abort_rst", 16'd5, 16'd7, 16'd13, 16'd15);

        // Random aborts and random frames on the small instance
        for (int t = 0; t < 6; t++) begin
            run_pixels(0, 1'($urandom), 2, 1'b1, 1'b1, 1'($urandom), $urandom_range(1, 15));
            step(0, 1'b0, 16'h0, 1'b1, 1'b0);
            run_frame(0, 1'($urandom), 3, 1'b1, 1'b1, 1'b0);
        end

        // Default geometry: two frames back to back
        for (int fr = 0; fr < 2; fr++) begin
            got_q.delete(); fin_cnt = 0;
            run_frame(1, 1'(fr), 2, 1'b0, 1'b0, 1'b0);
            check_value($sformatf("dflt_nout_%0d", fr), 32'(got_q.size()), 32'd144);
            check_value($sformatf("dflt_fin_%0d", fr), 32'(fin_cnt), 32'd1);
        end

        // POOL_K=4 instance, both modes, extremes and random data
        run_frame(2, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        run_frame(2, 1'b0, 3, 1'b1, 1'b1, 1'b0);
        run_frame(2, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        run_frame(2, 1'b0, 2, 1'b0, 1'b0, 1'b1);
        run_pixels(2, 1'b1, 2, 1'b0, 1'b0, 1'b0, 37);
        step(2, 1'b0, 16'h0, 1'b1, 1'b0);
        got_q.delete();
        run_frame(2, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        check_value("k4_nout", 32'(got_q.size()), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
